data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/data_memory.sv | 70 +++++++
 tb/tb_data_memory.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// Word-addressed 32-bit data memory: combinational read, synchronous write, async clear on reset.
// Optional misalignment rejection enabled by defining DATA_MEMORY_ALIGN_CHECK_EN.
module data_memory #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned ADDR_BITS   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 MemWrite,
  input  logic [ADDR_BITS-1:0] Address,
  input  logic [31:0]          WriteData,
  output logic [31:0]          ReadData,
  output logic                 AddrError
);

  localparam int unsigned IdxW = ADDR_BITS - 2;
  localparam int unsigned MemAw = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [IdxW-1:0]  word_idx;
  logic [MemAw-1:0] mem_idx;
  logic             in_range;
  logic             misaligned;
  logic             access_ok;

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] mem_d [DEPTH_WORDS];

  // Full upper-address compare so high bits never alias onto low words.
  assign word_idx = Address[ADDR_BITS-1:2];
  assign mem_idx  = word_idx[MemAw-1:0];
  assign in_range = (word_idx < IdxW'(DEPTH_WORDS));

`ifdef DATA_MEMORY_ALIGN_CHECK_EN
  assign misaligned = |Address[1:0];
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^Address[1:0];
  assign misaligned      = 1'b0;
`endif

  assign access_ok = in_range && !misaligned;
  assign AddrError = !access_ok;

  always_comb begin
    ReadData = 32'h0;
    if (access_ok) begin
      ReadData = mem_q[mem_idx];
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (MemWrite && access_ok) begin
      mem_d[mem_idx] = WriteData;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
        mem_q[i] <= 32'h0;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory; expectations follow DATA_MEMORY_ALIGN_CHECK_EN.
module tb_data_memory;

  localparam int unsigned DepthWords = 256;
  localparam int unsigned AddrBits   = 32;

  logic                clk;
  logic                reset;
  logic                MemWrite;
  logic [AddrBits-1:0] Address;
  logic [31:0]         WriteData;
  logic [31:0]         ReadData;
  logic                AddrError;

  int n_checks;
  int n_errors;

  data_memory #(
    .DEPTH_WORDS(DepthWords),
    .ADDR_BITS  (AddrBits)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .MemWrite (MemWrite),
    .Address  (Address),
    .WriteData(WriteData),
    .ReadData (ReadData),
    .AddrError(AddrError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    Address   = addr;
    WriteData = data;
    MemWrite  = 1'b1;
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                            input logic exp_err);
    Address = addr;
    #1;
    check_eq({tag, ".data"}, ReadData, exp_data);
    check_eq({tag, ".err"}, {31'h0, AddrError}, {31'h0, exp_err});
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b1;
    MemWrite  = 1'b0;
    Address   = '0;
    WriteData = '0;
    #22;
    reset = 1'b0;

    read_check("rst_a0", 32'h0, 32'h0, 1'b0);
    read_check("rst_a4", 32'h4, 32'h0, 1'b0);

    // Write then read at unchanged address right after the edge.
    do_write(32'h0, 32'hDEADBEEF);
    check_eq("wr0_imm", ReadData, 32'hDEADBEEF);
    read_check("wr0", 32'h0, 32'hDEADBEEF, 1'b0);

    do_write(32'h4, 32'hCAFEBABE);
    read_check("wr4", 32'h4, 32'hCAFEBABE, 1'b0);
    read_check("wr4_w0", 32'h0, 32'hDEADBEEF, 1'b0);

    // Out of range: first index past the end, and a high address bit.
    do_write(4 * DepthWords, 32'h12345678);
    check_eq("oor.err", {31'h0, AddrError}, 32'h1);
    check_eq("oor.data", ReadData, 32'h0);
    read_check("oor_w0", 32'h0, 32'hDEADBEEF, 1'b0);
    do_write(32'h8000_0000, 32'h0BAD0BAD);
    check_eq("hi.err", {31'h0, AddrError}, 32'h1);
    check_eq("hi.data", ReadData, 32'h0);
    read_check("hi_w0", 32'h0, 32'hDEADBEEF, 1'b0);

    do_write(4 * (DepthWords - 1), 32'h11111111);
    read_check("last", 4 * (DepthWords - 1), 32'h11111111, 1'b0);

    // Back-to-back writes to the same word keep the last.
    @(negedge clk);
    Address   = 32'h8;
    MemWrite  = 1'b1;
    WriteData = 32'hAAAA0001;
    @(negedge clk);
    WriteData = 32'hAAAA0002;
    @(negedge clk);
    MemWrite  = 1'b0;
    read_check("b2b", 32'h8, 32'hAAAA0002, 1'b0);

    // MemWrite=0 with data toggling across edges leaves memory alone.
    WriteData = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    WriteData = 32'h00000000;
    @(posedge clk);
    #1;
    read_check("nowr", 32'h8, 32'hAAAA0002, 1'b0);

    // Data changing between edges: only the edge-sampled value lands.
    @(negedge clk);
    Address   = 32'hC;
    WriteData = 32'h55550001;
    MemWrite  = 1'b1;
    @(posedge clk);
    #1;
    WriteData = 32'h55550002;
    MemWrite  = 1'b0;
    #2;
    check_eq("sample", ReadData, 32'h55550001);

    do_write(32'h2, 32'hA5A5A5A5);
`ifdef DATA_MEMORY_ALIGN_CHECK_EN
    check_eq("mis.err", {31'h0, AddrError}, 32'h1);
    check_eq("mis.data", ReadData, 32'h0);
    read_check("mis_w0", 32'h0, 32'hDEADBEEF, 1'b0);
    read_check("mis_6", 32'h6, 32'h0, 1'b1);
`else
    check_eq("mis.err", {31'h0, AddrError}, 32'h0);
    check_eq("mis.data", ReadData, 32'hA5A5A5A5);
    read_check("mis_w0", 32'h0, 32'hA5A5A5A5, 1'b0);
    read_check("mis_6", 32'h6, 32'hCAFEBABE, 1'b0);
`endif

    // Reset between edges clears immediately, and blocks writes while held.
    @(posedge clk);
    #2;
    Address = 32'h4;
    reset   = 1'b1;
    #1;
    check_eq("arst_a4", ReadData, 32'h0);
    Address = 32'h0;
    #1;
    check_eq("arst_a0", ReadData, 32'h0);
    Address = 4 * DepthWords;
    #1;
    check_eq("arst_oor.err", {31'h0, AddrError}, 32'h1);
    Address   = 32'h8;
    WriteData = 32'h77777777;
    MemWrite  = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_blk", ReadData, 32'h0);
    MemWrite = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    read_check("post_a8", 32'h8, 32'h0, 1'b0);
    read_check("post_last", 4 * (DepthWords - 1), 32'h0, 1'b0);

    do_write(32'h10, 32'h0F0F0F0F);
    read_check("post_wr", 32'h10, 32'h0F0F0F0F, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
